// File: rtl/calc_cu.sv
// calc_cu: Moore controller for the 4-bit calculator datapath.
// A go request clears R0, loads in1/in2 into R1/R2, runs the latched opcode
// into R3, then presents R3 on the output with done high until go drops.
// Control outputs are registered: each edge loads the decode of the state
// being entered, so they always match the decode of the current cs.
module calc_cu #(
   parameter logic [1:0] ZERO_ADDR = 2'b00,
   parameter logic [1:0] A_ADDR    = 2'b01,
   parameter logic [1:0] B_ADDR    = 2'b10,
   parameter logic [1:0] RES_ADDR  = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [1:0] op,
   output logic [1:0] s1,
   output logic [1:0] wa,
   output logic       we,
   output logic [1:0] raa,
   output logic       rea,
   output logic [1:0] rab,
   output logic       reb,
   output logic [1:0] c,
   output logic       s2,
   output logic       done,
   output logic       busy,
   output logic [2:0] cs
);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      INIT  = 3'b001,
      LOAD1 = 3'b010,
      LOAD2 = 3'b011,
      EXEC  = 3'b100,
      DONE  = 3'b101
   } state_t;

   typedef struct packed {
      logic [1:0] s1;
      logic [1:0] wa;
      logic       we;
      logic [1:0] raa;
      logic       rea;
      logic [1:0] rab;
      logic       reb;
      logic [1:0] c;
      logic       s2;
      logic       done;
      logic       busy;
   } ctl_t;

   state_t     st;
   logic [1:0] op_r;
   ctl_t       ctl_q;

   // Sequencing: every non-IDLE/DONE state advances unconditionally.
   function automatic state_t next_of(input state_t s, input logic g);
      state_t n;
      n = IDLE;
      case (s)
         IDLE:    n = g ? INIT : IDLE;
         INIT:    n = LOAD1;
         LOAD1:   n = LOAD2;
         LOAD2:   n = EXEC;
         EXEC:    n = DONE;
         DONE:    n = g ? DONE : IDLE;
         default: n = IDLE;
      endcase
      return n;
   endfunction

   // Per-state control word; anything not set stays zero.
   function automatic ctl_t decode(input state_t s, input logic [1:0] opc);
      ctl_t k;
      k = '0;
      case (s)
         INIT: begin
            k.s1 = 2'b01; k.wa = ZERO_ADDR; k.we = 1'b1; k.busy = 1'b1;
         end
         LOAD1: begin
            k.s1 = 2'b11; k.wa = A_ADDR; k.we = 1'b1; k.busy = 1'b1;
         end
         LOAD2: begin
            k.s1 = 2'b10; k.wa = B_ADDR; k.we = 1'b1; k.busy = 1'b1;
         end
         EXEC: begin
            k.rea = 1'b1; k.raa = A_ADDR; k.reb = 1'b1; k.rab = B_ADDR;
            k.c = opc; k.s1 = 2'b00; k.wa = RES_ADDR; k.we = 1'b1;
            k.busy = 1'b1;
         end
         DONE: begin
            // R3 + R0 (zero) through the ALU puts the result on the output.
            k.rea = 1'b1; k.raa = RES_ADDR; k.reb = 1'b1; k.rab = ZERO_ADDR;
            k.c = 2'b00; k.s2 = 1'b1; k.done = 1'b1;
         end
         default: k = '0;
      endcase
      return k;
   endfunction

   // State, opcode latch and registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= IDLE;
         op_r  <= 2'b00;
         ctl_q <= decode(IDLE, 2'b00);
      end else begin
         st    <= next_of(st, go);
         if (st == IDLE && go)
            op_r <= op;
         // op_r is already settled whenever EXEC is the state being entered.
         ctl_q <= decode(next_of(st, go), op_r);
      end
   end

   assign cs   = st;
   assign s1   = ctl_q.s1;
   assign wa   = ctl_q.wa;
   assign we   = ctl_q.we;
   assign raa  = ctl_q.raa;
   assign rea  = ctl_q.rea;
   assign rab  = ctl_q.rab;
   assign reb  = ctl_q.reb;
   assign c    = ctl_q.c;
   assign s2   = ctl_q.s2;
   assign done = ctl_q.done;
   assign busy = ctl_q.busy;

endmodule
